queue_calc_unit: RTL

QUEUE_CALC_UNIT -- requirements
Module: queue_calc_unit

---
 rtl/queue_calc_unit_if.sv | 22 ++
 rtl/queue_calc_unit.sv | 118 +++++++++++
 2 files changed

// File: rtl/queue_calc_unit_if.sv
// Handshake bundle between the queue calculator and its host/queue.
// The slave modport is the calculator's view; master is the driver's view.
interface queue_calc_unit_if;
  logic        start;
  logic [1:0]  op_sel;
  logic [15:0] top_conc;
  logic [1:0]  queue_opcode;
  logic [15:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        busy;

  modport slave (
    input  start, op_sel, top_conc, result_ready,
    output queue_opcode, result, result_valid, busy
  );

  modport master (
    output start, op_sel, top_conc, result_ready,
    input  queue_opcode, result, result_valid, busy
  );
endinterface

// File: rtl/queue_calc_unit.sv
// Pops a pair of operands from the queue head, computes add/sub/mul/max on them,
// and holds the result under a valid/ready handshake.
module queue_calc_unit #(
  parameter logic [1:0] QOP_NOP  = 2'b01,
  parameter logic [1:0] QOP_POP2 = 2'b11
) (
  input  logic               clk,
  input  logic               rst,
  queue_calc_unit_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CAPTURE, EXEC, POP, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] result_q, result_d;

  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [15:0] partial;
  logic [15:0] mul_sum;

  assign sum9    = {1'b0, a_q} + {1'b0, b_q};
  assign diff9   = {1'b0, a_q} - {1'b0, b_q};
  // One multiplier bit per EXEC edge, LSB first; the multiplicand is shifted by the bit index.
  assign partial = b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : 16'h0000;
  assign mul_sum = acc_q + partial;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op_sel;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        a_d     = bus.top_conc[15:8];
        b_d     = bus.top_conc[7:0];
        acc_d   = 16'h0000;
        cnt_d   = 3'd0;
        state_d = EXEC;
      end
      EXEC: begin
        case (op_q)
          2'b00: begin
            result_d = {7'b0, sum9};
            state_d  = POP;
          end
          2'b01: begin
            result_d = {{7{diff9[8]}}, diff9};
            state_d  = POP;
          end
          2'b10: begin
            acc_d = mul_sum;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              result_d = mul_sum;
              state_d  = POP;
            end
          end
          default: begin
            result_d = {8'h00, (a_q >= b_q) ? a_q : b_q};
            state_d  = POP;
          end
        endcase
      end
      POP: begin
        state_d = DONE;
      end
      DONE: begin
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      cnt_q    <= 3'd0;
      acc_q    <= 16'h0000;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.queue_opcode = (state_q == POP) ? QOP_POP2 : QOP_NOP;
  assign bus.result       = result_q;

endmodule
